// File: rtl/bcd_to_bin_if.sv
// Handshake bundle for the BCD-to-binary converter: request side (start,
// bcd_in) and result side (busy, done, bin_out, err).
interface bcd_to_bin_if #(
   parameter int DIGITS = 4,
   parameter int BIN_W  = 14
);
   logic                  start;
   logic [4*DIGITS-1:0]   bcd_in;
   logic                  busy;
   logic                  done;
   logic [BIN_W-1:0]      bin_out;
   logic                  err;

   // Requester: drives the request, observes the result.
   modport master (
      output start, bcd_in,
      input  busy, done, bin_out, err
   );

   // Converter: observes the request, drives the result.
   modport slave (
      input  start, bcd_in,
      output busy, done, bin_out, err
   );
endinterface

// File: rtl/bcd_to_bin.sv
// Sequential packed-BCD to binary converter using reverse double dabble.
// One shift/correct step per clock, BIN_W steps per conversion. A request
// holding any digit above 9 is rejected immediately with err and a done pulse.
module bcd_to_bin #(
   parameter int DIGITS = 4,
   parameter int BIN_W  = 14
) (
   input  logic        clk,
   input  logic        reset,
   bcd_to_bin_if.slave bus
);

   localparam int BCD_W = 4 * DIGITS;
   localparam int SR_W  = BCD_W + BIN_W;

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_CONVERT = 2'd1;
   localparam logic [1:0] S_FINISH  = 2'd2;

   localparam logic [3:0] LAST_STEP = 4'(BIN_W - 1);

   logic [1:0]       state;
   logic [3:0]       step;
   logic [SR_W-1:0]  shift_reg;
   logic [SR_W-1:0]  shift_next;
   logic [BIN_W-1:0] bin_reg;
   logic             err_reg;
   logic             bad_digit;

   // Flag a request whose packed BCD word contains any nibble above 9.
   always_comb begin
      bad_digit = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (bus.bcd_in[4*i +: 4] > 4'd9) begin
            bad_digit = 1'b1;
         end
      end
   end

   // One reverse double-dabble step: shift the whole {bcd, bin} register right,
   // then pull 3 from every BCD digit that landed at 8 or more.
   always_comb begin
      shift_next = shift_reg >> 1;
      for (int i = 0; i < DIGITS; i++) begin
         if (shift_next[BIN_W + 4*i +: 4] >= 4'd8) begin
            shift_next[BIN_W + 4*i +: 4] = shift_next[BIN_W + 4*i +: 4] - 4'd3;
         end
      end
   end

   // Control FSM, step counter, shift register and held result/error outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= S_IDLE;
         step      <= 4'd0;
         shift_reg <= '0;
         bin_reg   <= '0;
         err_reg   <= 1'b0;
      end else begin
         case (state)
            S_IDLE, S_FINISH: begin
               if (bus.start) begin
                  if (bad_digit) begin
                     err_reg <= 1'b1;
                     bin_reg <= '0;
                     state   <= S_FINISH;
                  end else begin
                     err_reg   <= 1'b0;
                     shift_reg <= {bus.bcd_in, {BIN_W{1'b0}}};
                     step      <= 4'd0;
                     state     <= S_CONVERT;
                  end
               end else begin
                  state <= S_IDLE;
               end
            end
            S_CONVERT: begin
               shift_reg <= shift_next;
               step      <= step + 4'd1;
               if (step == LAST_STEP) begin
                  bin_reg <= shift_next[BIN_W-1:0];
                  state   <= S_FINISH;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.busy    = (state == S_CONVERT);
   assign bus.done    = (state == S_FINISH);
   assign bus.bin_out = bin_reg;
   assign bus.err     = err_reg;

endmodule

// File: tb/tb_bcd_to_bin.sv
// Directed bench for bcd_to_bin: reset state, conversions, back-to-back
// requests, invalid digits, ignored starts and reset mid-conversion.
module tb_bcd_to_bin;

   logic clk;
   logic reset;
   int   vectors;
   int   miscompares;
   int   lat;
   int   busy_cnt;
   int   overlap;
   int   done_seen;

   bcd_to_bin_if #(.DIGITS(4), .BIN_W(14)) bus ();

   bcd_to_bin #(.DIGITS(4), .BIN_W(14)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   // Free-running 10-unit clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance to 1 unit past the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic st, input logic [15:0] bcd);
      bus.start  = st;
      bus.bcd_in = bcd;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Wait for done with a bound; lat starts from the caller's count, counts
   // busy cycles and any cycle with busy and done together.
   task automatic waitDone(input int start_lat);
      lat      = start_lat;
      overlap  = 0;
      busy_cnt = bus.busy ? 1 : 0;
      while (!bus.done && lat < 40) begin
         tick();
         lat++;
         if (bus.busy) busy_cnt++;
         if (bus.busy && bus.done) overlap++;
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      reset       = 1'b0;
      applyStimulus(1'b0, 16'h0000);
      tick();
      tick();

      checkOutput("reset_busy", 32'(bus.busy), 0);
      checkOutput("reset_done", 32'(bus.done), 0);
      checkOutput("reset_err", 32'(bus.err), 0);
      checkOutput("reset_bin", 32'(bus.bin_out), 0);
      reset = 1'b1;
      tick();

      // Zero input
      applyStimulus(1'b1, 16'h0000);
      tick();
      applyStimulus(1'b0, 16'h0000);
      checkOutput("zero_busy_after_accept", 32'(bus.busy), 1);
      waitDone(0);
      checkOutput("zero_latency", lat, 14);
      checkOutput("zero_bin", 32'(bus.bin_out), 0);
      checkOutput("zero_err", 32'(bus.err), 0);
      tick();
      checkOutput("zero_done_single", 32'(bus.done), 0);

      // Maximum value 9999
      applyStimulus(1'b1, 16'h9999);
      tick();
      applyStimulus(1'b0, 16'h0000);
      waitDone(0);
      checkOutput("max_latency", lat, 14);
      checkOutput("max_busy_cycles", busy_cnt, 14);
      checkOutput("max_overlap", overlap, 0);
      checkOutput("max_bin", 32'(bus.bin_out), 9999);
      tick();
      checkOutput("max_done_single", 32'(bus.done), 0);

      // Back-to-back: 1234 then 0050 started in the done cycle
      applyStimulus(1'b1, 16'h1234);
      tick();
      applyStimulus(1'b0, 16'h0000);
      waitDone(0);
      checkOutput("b2b_first_latency", lat, 14);
      checkOutput("b2b_first_bin", 32'(bus.bin_out), 1234);
      applyStimulus(1'b1, 16'h0050);
      tick();
      applyStimulus(1'b0, 16'h0000);
      checkOutput("b2b_second_busy", 32'(bus.busy), 1);
      checkOutput("b2b_bin_held", 32'(bus.bin_out), 1234);
      waitDone(1);
      checkOutput("b2b_done_spacing", lat, 15);
      checkOutput("b2b_second_bin", 32'(bus.bin_out), 50);
      tick();

      // Invalid digit, then a valid request clears err
      applyStimulus(1'b1, 16'h12A4);
      tick();
      applyStimulus(1'b0, 16'h0000);
      checkOutput("inv_done", 32'(bus.done), 1);
      checkOutput("inv_busy", 32'(bus.busy), 0);
      checkOutput("inv_err", 32'(bus.err), 1);
      checkOutput("inv_bin", 32'(bus.bin_out), 0);
      tick();
      checkOutput("inv_done_single", 32'(bus.done), 0);
      checkOutput("inv_err_held", 32'(bus.err), 1);
      applyStimulus(1'b1, 16'h0007);
      tick();
      applyStimulus(1'b0, 16'h0000);
      waitDone(0);
      checkOutput("after_inv_latency", lat, 14);
      checkOutput("after_inv_err", 32'(bus.err), 0);
      checkOutput("after_inv_bin", 32'(bus.bin_out), 7);
      tick();

      // Start during conversion is ignored
      applyStimulus(1'b1, 16'h0456);
      tick();
      applyStimulus(1'b0, 16'h0000);
      tick();
      tick();
      tick();
      applyStimulus(1'b1, 16'h0001);
      tick();
      applyStimulus(1'b0, 16'h0000);
      waitDone(4);
      checkOutput("ignore_latency", lat, 14);
      checkOutput("ignore_bin", 32'(bus.bin_out), 456);
      tick();
      checkOutput("ignore_no_reaccept_busy", 32'(bus.busy), 0);
      checkOutput("ignore_no_reaccept_done", 32'(bus.done), 0);

      // Reset mid-conversion of 8765 at step 7
      applyStimulus(1'b1, 16'h8765);
      tick();
      applyStimulus(1'b0, 16'h0000);
      for (int i = 0; i < 7; i++) tick();
      checkOutput("abort_busy_before", 32'(bus.busy), 1);
      #2;
      reset = 1'b0;
      #1;
      checkOutput("abort_busy", 32'(bus.busy), 0);
      checkOutput("abort_done", 32'(bus.done), 0);
      checkOutput("abort_bin", 32'(bus.bin_out), 0);
      checkOutput("abort_err", 32'(bus.err), 0);
      tick();
      tick();
      reset = 1'b1;
      done_seen = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (bus.done || bus.busy) done_seen++;
      end
      checkOutput("abort_no_done", done_seen, 0);
      applyStimulus(1'b1, 16'h0042);
      tick();
      applyStimulus(1'b0, 16'h0000);
      waitDone(0);
      checkOutput("post_reset_latency", lat, 14);
      checkOutput("post_reset_bin", 32'(bus.bin_out), 42);
      checkOutput("post_reset_err", 32'(bus.err), 0);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
